// File: rtl/sr_latch_sequencer.sv
// Sequences timed, non-overlapping S/R pulses into a NOR SR latch and verifies the result.
// Latency: write done at accept+PULSE_W+SETTLE+2, read done at accept+SETTLE+2 cycles.
// Backpressure: cmd_ready is high only in IDLE; one command in flight at a time.
module sr_latch_sequencer #(
    parameter int PULSE_W = 4,
    parameter int SETTLE  = 3,
    parameter int ERR_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd_op,
    output logic             cmd_ready,
    output logic             latch_s,
    output logic             latch_r,
    input  logic             latch_q,
    input  logic             latch_qn,
    output logic             done,
    output logic             q_state,
    output logic             fault,
    output logic [ERR_W-1:0] err_cnt,
    input  logic             clr_err
);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_PULSE,
        S_SETTLE,
        S_CHECK
    } state_t;

    localparam logic [1:0] OP_READ   = 2'b00;
    localparam logic [1:0] OP_SET    = 2'b01;
    localparam logic [1:0] OP_RESET  = 2'b10;
    localparam logic [1:0] OP_TOGGLE = 2'b11;

    localparam int CNT_MAX = (PULSE_W > SETTLE) ? PULSE_W : SETTLE;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] PULSE_LD  = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       op_q, op_nxt;
    logic             target_q, target_nxt;
    logic             init_q, init_nxt;
    logic             s_nxt, r_nxt, done_nxt, q_state_nxt;
    logic             tgt;
    logic [1:0]       q_sync, qn_sync;
    logic             qs, qns;
    logic             fault_ev;

    assign qs  = q_sync[1];
    assign qns = qn_sync[1];

    // Q/Qn come straight from the analog latch and may be metastable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_sync  <= 2'b00;
            qn_sync <= 2'b00;
        end else begin
            q_sync  <= {q_sync[0], latch_q};
            qn_sync <= {qn_sync[0], latch_qn};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_INIT;
            cnt      <= '0;
            op_q     <= OP_READ;
            target_q <= 1'b0;
            init_q   <= 1'b0;
            latch_s  <= 1'b0;
            latch_r  <= 1'b0;
            done     <= 1'b0;
            q_state  <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            op_q     <= op_nxt;
            target_q <= target_nxt;
            init_q   <= init_nxt;
            latch_s  <= s_nxt;
            latch_r  <= r_nxt;
            done     <= done_nxt;
            q_state  <= q_state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        op_nxt      = op_q;
        target_nxt  = target_q;
        init_nxt    = init_q;
        s_nxt       = latch_s;
        r_nxt       = latch_r;
        done_nxt    = 1'b0;
        q_state_nxt = q_state;
        cmd_ready   = 1'b0;
        tgt         = target_q;

        case (state)
            // Power-up behaves like a silent reset command so the latch starts known.
            S_INIT: begin
                op_nxt     = OP_RESET;
                target_nxt = 1'b0;
                init_nxt   = 1'b1;
                s_nxt      = 1'b0;
                r_nxt      = 1'b1;
                cnt_nxt    = PULSE_LD;
                state_nxt  = S_PULSE;
            end
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_SET:    tgt = 1'b1;
                        OP_RESET:  tgt = 1'b0;
                        OP_TOGGLE: tgt = ~q_state;
                        default:   tgt = q_state;
                    endcase
                    op_nxt     = cmd_op;
                    target_nxt = tgt;
                    init_nxt   = 1'b0;
                    if (cmd_op == OP_READ) begin
                        cnt_nxt   = SETTLE_LD;
                        state_nxt = S_SETTLE;
                    end else begin
                        s_nxt     = tgt;
                        r_nxt     = ~tgt;
                        cnt_nxt   = PULSE_LD;
                        state_nxt = S_PULSE;
                    end
                end
            end
            S_PULSE: begin
                if (cnt == '0) begin
                    s_nxt     = 1'b0;
                    r_nxt     = 1'b0;
                    cnt_nxt   = SETTLE_LD;
                    state_nxt = S_SETTLE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            S_SETTLE: begin
                if (cnt == '0) begin
                    state_nxt = S_CHECK;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            S_CHECK: begin
                done_nxt    = ~init_q;
                q_state_nxt = qs;
                state_nxt   = S_IDLE;
            end
            default: begin
                s_nxt     = 1'b0;
                r_nxt     = 1'b0;
                state_nxt = S_INIT;
            end
        endcase
    end

    assign fault_ev = (state == S_CHECK) &&
                      ((qs == qns) || ((op_q != OP_READ) && (qs != target_q)));

    // A fault in the same cycle as clr_err restarts the count at one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault   <= 1'b0;
            err_cnt <= '0;
        end else if (fault_ev) begin
            fault <= 1'b1;
            if (clr_err)
                err_cnt <= ERR_W'(1);
            else if (!(&err_cnt))
                err_cnt <= err_cnt + ERR_W'(1);
        end else if (clr_err) begin
            fault   <= 1'b0;
            err_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_sr_latch_sequencer.sv
// Directed bench for sr_latch_sequencer with a behavioural latch model that can be
// forced into a both-high or stuck-at-0 condition.
module tb_sr_latch_sequencer;

    localparam int PW = 4;
    localparam int ST = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'b00;
    logic       cmd_ready;
    logic       latch_s, latch_r;
    logic       latch_q, latch_qn;
    logic       done, q_state, fault;
    logic [3:0] err_cnt;
    logic       clr_err = 1'b0;

    logic       mq = 1'b0;
    logic [1:0] mode = 2'd0;   // 0 normal, 1 Q=Qn=1, 2 stuck at Q=0
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (latch_s)      mq <= 1'b1;
        else if (latch_r) mq <= 1'b0;
    end

    assign latch_q  = (mode == 2'd1) ? 1'b1 : (mode == 2'd2) ? 1'b0 : mq;
    assign latch_qn = (mode == 2'd1) ? 1'b1 : (mode == 2'd2) ? 1'b1 : ~mq;

    sr_latch_sequencer #(.PULSE_W(PW), .SETTLE(ST), .ERR_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_op    (cmd_op),
        .cmd_ready (cmd_ready),
        .latch_s   (latch_s),
        .latch_r   (latch_r),
        .latch_q   (latch_q),
        .latch_qn  (latch_qn),
        .done      (done),
        .q_state   (q_state),
        .fault     (fault),
        .err_cnt   (err_cnt),
        .clr_err   (clr_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Release reset just after an edge; the next edge is cycle 0 of the INIT sequence.
    task automatic init_release();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        for (int i = 1; i <= 8; i++) begin
            chk("init_r", 32'(latch_r), 32'(i <= PW));
            chk("init_s", 32'(latch_s), 32'd0);
            chk("init_ready", 32'(cmd_ready), 32'd0);
            chk("init_done", 32'(done), 32'd0);
            tick();
        end
        chk("init_ready9", 32'(cmd_ready), 32'd1);
        chk("init_done9", 32'(done), 32'd0);
        chk("init_fault", 32'(fault), 32'd0);
        chk("init_q", 32'(q_state), 32'd0);
    endtask

    // Called while the DUT is in IDLE; returns in the done cycle (DUT back in IDLE).
    task automatic do_cmd(input logic [1:0] op, input logic exp_s, input logic exp_r,
                          input logic clr_at_check);
        int lat;
        lat = (op == 2'b00) ? ST + 2 : PW + ST + 2;
        cmd_valid = 1'b1;
        cmd_op    = op;
        tick();
        for (int j = 1; j <= lat; j++) begin
            if (j < lat) begin
                chk("cmd_s", 32'(latch_s), 32'(exp_s && (j <= PW)));
                chk("cmd_r", 32'(latch_r), 32'(exp_r && (j <= PW)));
                chk("cmd_busy_done", 32'(done), 32'd0);
                chk("cmd_busy_ready", 32'(cmd_ready), 32'd0);
            end else begin
                chk("cmd_done", 32'(done), 32'd1);
                chk("cmd_ready", 32'(cmd_ready), 32'd1);
                chk("cmd_end_s", 32'(latch_s), 32'd0);
                chk("cmd_end_r", 32'(latch_r), 32'd0);
            end
            // Garbage opcode while busy must be ignored.
            if (j == 1) cmd_op = ~op;
            if (j == lat - 1) clr_err = clr_at_check;
            if (j == lat) begin
                clr_err   = 1'b0;
                cmd_valid = 1'b0;
            end else begin
                tick();
            end
        end
    endtask

    initial begin
        #3;
        chk("rst_s", 32'(latch_s), 32'd0);
        chk("rst_r", 32'(latch_r), 32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_q", 32'(q_state), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_err", 32'(err_cnt), 32'd0);

        init_release();

        do_cmd(2'b01, 1'b1, 1'b0, 1'b0);
        chk("set_q", 32'(q_state), 32'd1);
        chk("set_fault", 32'(fault), 32'd0);

        do_cmd(2'b11, 1'b0, 1'b1, 1'b0);
        chk("tog1_q", 32'(q_state), 32'd0);
        do_cmd(2'b11, 1'b1, 1'b0, 1'b0);
        chk("tog2_q", 32'(q_state), 32'd1);

        do_cmd(2'b00, 1'b0, 1'b0, 1'b0);
        chk("read_q", 32'(q_state), 32'd1);
        chk("read_fault", 32'(fault), 32'd0);

        mode = 2'd1;
        do_cmd(2'b00, 1'b0, 1'b0, 1'b0);
        chk("bad_read_q", 32'(q_state), 32'd1);
        chk("bad_read_fault", 32'(fault), 32'd1);
        chk("bad_read_err", 32'(err_cnt), 32'd1);
        tick();
        chk("done_one_cycle", 32'(done), 32'd0);
        mode = 2'd0;

        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("clr_fault", 32'(fault), 32'd0);
        chk("clr_err", 32'(err_cnt), 32'd0);

        mode = 2'd2;
        for (int i = 1; i <= 16; i++) begin
            do_cmd(2'b01, 1'b1, 1'b0, 1'b0);
            chk("stuck_err", 32'(err_cnt), (i > 15) ? 32'd15 : 32'(i));
            chk("stuck_fault", 32'(fault), 32'd1);
            chk("stuck_q", 32'(q_state), 32'd0);
        end
        do_cmd(2'b01, 1'b1, 1'b0, 1'b1);
        chk("clr_vs_fault_flag", 32'(fault), 32'd1);
        chk("clr_vs_fault_cnt", 32'(err_cnt), 32'd1);
        mode = 2'd0;

        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        tick();
        cmd_valid = 1'b0;
        chk("mid_s1", 32'(latch_s), 32'd1);
        tick();
        chk("mid_s2", 32'(latch_s), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_s", 32'(latch_s), 32'd0);
        chk("mid_rst_r", 32'(latch_r), 32'd0);
        chk("mid_rst_ready", 32'(cmd_ready), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_err", 32'(err_cnt), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mid_rst_hold_done", 32'(done), 32'd0);
            chk("mid_rst_hold_s", 32'(latch_s), 32'd0);
        end
        init_release();
        chk("final_err", 32'(err_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
